cosine_sim: RTL and testbench
=============================

# cosine_sim

Sequential fixed-point cosine-similarity engine. It computes cos(θ) = (a·b) / (‖a‖·‖b‖) for two W-element signed vectors. The operands are latched on a start pulse and processed by a multi-cycle datapath (accumulate, square root, multiply, divide). The result is returned as a signed fixed-point value with a one-cycle valid pulse. It sits as a compute leaf behind a simple start/valid handshake.

## Interface
- W, default 5: number of vector elements (≥1).
- clk  in  1: single clock; all state updates on rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: request; sampled only in IDLE.
- vec_a  in  W×32 (unpacked [W-1:0] of logic [31:0]): vector A; each element is signed two's complement with FRAC=15 fraction bits (1.0 = 32'h0000_8000).
- vec_b  in  W×32: vector B, same format as vec_a.
- sim  out  32: similarity, signed, FRAC=15, range −32768…+32768.
- valid  out  1: one-cycle pulse when sim is updated.

## Operation
- States: IDLE → ACCUM → SQRT → MUL → DIV → DONE → IDLE.
- IDLE: when start=1 at a rising edge, latch all vec_a/vec_b elements and go to ACCUM. Inputs may change afterwards.
- ACCUM, W cycles, one element per cycle. Three 64-bit signed products (a_i·b_i, a_i², b_i²) are summed into 72-bit signed accumulators dot, na2 and nb2 (Q.30).
- SQRT, 36 cycles. Two parallel radix-2 restoring integer square roots: norm_a = floor(√na2) and norm_b = floor(√nb2), both Q.15, 36-bit unsigned.
- MUL, 1 cycle: denom = norm_a·norm_b (72-bit unsigned, Q.30).
- DIV, 18 cycles. Restoring division of |dot|<<15 by denom, producing an 18-bit magnitude quotient truncated toward zero.
  - Sign is applied afterwards from dot.
  - Magnitude is clamped to 32768.
  - If denom==0 (either vector all zero), the result is 0.
- DONE, 1 cycle: register sim, assert valid, return to IDLE.
- sim holds its value until the next DONE. start outside IDLE is ignored, with no queuing.
- Arithmetic is exact until the final truncation. Accumulators cannot overflow for W ≤ 256.

## Timing
- Reset values: sim=0, valid=0, state=IDLE, all datapath registers 0.
- Latency is fixed: valid is high for exactly one cycle, W+56 cycles after the edge that sampled start. No early termination on zero operands.
- Back-to-back: start can be accepted in the cycle after DONE, i.e. valid and start may overlap only in that start is ignored during DONE.
- Reset asserted mid-operation aborts immediately. Outputs return to reset values and no valid is produced for the aborted request.

## Structure
- Package cosine_sim_pkg contains:
  - DATA_W=32, FRAC=15, ACC_W=72, ROOT_W=36, ONE=32'sd32768.
  - The state enum type.
  - Latency constants for SQRT and DIV.
- Sub-module isqrt_seq: sequential radix-2 integer square root with start/done, 72-bit in, 36-bit out. Instantiated twice.
- Division stays inline in cosine_sim.

## Test plan
- A=B=[1.0×5] → sim=32'h0000_8000 (+1.0); valid one cycle at start+W+56.
- A=[1.0×5], B=[−1.0×5] → sim=32'hFFFF_8000 (−1.0).
- A=[1,0,0,0,0], B=[0,1,0,0,0] (×1.0) → sim=0.
- A=[1,1,0,0,0], B=[1,0,0,0,0] → sim=23170 ±1 LSB (0.7071).
- A all zero, B=[1.0×5] → sim=0, valid still pulses at nominal latency.
- Reset asserted mid-DIV, then new start with A=B=[2.0,−3.0,0.5,0,1.0] → no stale valid; second result +1.0. Also, start pulsed while busy is ignored: exactly one valid per accepted start.

Source files
------------

// File: rtl/cosine_sim_pkg.sv
// Shared widths, fixed-point constants, FSM state type and phase lengths
// for the cosine-similarity engine.
package cosine_sim_pkg;

    localparam int DATA_W = 32;
    localparam int FRAC   = 15;
    localparam int ACC_W  = 72;
    localparam int ROOT_W = 36;
    localparam int Q_W    = 18;
    localparam logic signed [DATA_W-1:0] ONE = 32'sd32768;

    localparam int SQRT_CYC = 36;
    localparam int DIV_CYC  = 18;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_SQRT,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

endpackage

// File: rtl/cosine_sim_isqrt_seq.sv
// Sequential radix-2 restoring integer square root: 72-bit radicand,
// 36-bit floor root, one result bit per cycle over SQRT_CYC cycles.
module isqrt_seq
    import cosine_sim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ACC_W-1:0]  radicand,
    output logic [ROOT_W-1:0] root,
    output logic              done
);

    localparam int REM_W = ROOT_W + 2;
    localparam int CNT_W = 6;

    logic [ACC_W-1:0]  x_q, cur_x;
    logic [REM_W-1:0]  rem_q, cur_rem, nxt_rem;
    logic [ROOT_W-1:0] cur_root;
    logic [REM_W+1:0]  t_rem, trial;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q, load, ge;

    assign load = start && !busy_q;
    assign done = busy_q && (cnt_q == CNT_W'(SQRT_CYC - 1));

    // The load cycle already retires the first root bit, so the whole
    // operation fits exactly in SQRT_CYC cycles.
    always_comb begin
        cur_x    = load ? radicand : x_q;
        cur_rem  = load ? '0 : rem_q;
        cur_root = load ? '0 : root;
        t_rem    = {cur_rem, cur_x[ACC_W-1 -: 2]};
        trial    = {2'b00, cur_root, 2'b01};
        ge       = (t_rem >= trial);
        nxt_rem  = ge ? REM_W'(t_rem - trial) : REM_W'(t_rem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            rem_q  <= '0;
            root   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load || busy_q) begin
            x_q   <= {cur_x[ACC_W-3:0], 2'b00};
            rem_q <= nxt_rem;
            root  <= {cur_root[ROOT_W-2:0], ge};
            if (load) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(1);
            end else if (cnt_q == CNT_W'(SQRT_CYC - 1)) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cosine_sim.sv
// Fixed-point cosine similarity of two W-element Q.15 vectors with a
// fixed-latency start/valid handshake (accumulate, sqrt, multiply, divide).
module cosine_sim
    import cosine_sim_pkg::*;
#(
    parameter int W = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DATA_W-1:0]        vec_a [W-1:0],
    input  logic [DATA_W-1:0]        vec_b [W-1:0],
    output logic signed [DATA_W-1:0] sim,
    output logic                     valid
);

    localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
    localparam int CNT_W = 5;

    state_t                    state;
    logic signed [DATA_W-1:0]  a_q [W-1:0];
    logic signed [DATA_W-1:0]  b_q [W-1:0];
    logic [IDX_W-1:0]          idx;
    logic [CNT_W-1:0]          div_cnt;
    logic signed [ACC_W-1:0]   dot, na2, nb2;
    logic                      sq_go, sq_done_a, sq_done_b;
    logic [ROOT_W-1:0]         norm_a, norm_b;
    logic [ACC_W-1:0]          denom, div_rem, prod, abs_dot;
    logic [Q_W-1:0]            n_lo, quo;
    logic                      ovf, neg;
    logic signed [2*DATA_W-1:0] p_ab, p_aa, p_bb;
    logic [ACC_W:0]            div_trial;
    logic                      div_ge;

    function automatic logic signed [DATA_W-1:0] shape_result(
        input logic [Q_W-1:0] q,
        input logic           q_ovf,
        input logic           q_neg,
        input logic           zero_den
    );
        logic [Q_W-1:0]           mag;
        logic signed [DATA_W-1:0] s;
        mag = (q_ovf || (q > Q_W'(ONE))) ? Q_W'(ONE) : q;
        s   = signed'(DATA_W'(mag));
        if (zero_den)
            return '0;
        return q_neg ? -s : s;
    endfunction

    assign p_ab = a_q[idx] * b_q[idx];
    assign p_aa = a_q[idx] * a_q[idx];
    assign p_bb = b_q[idx] * b_q[idx];

    assign prod    = norm_a * norm_b;
    assign abs_dot = dot[ACC_W-1] ? unsigned'(-dot) : unsigned'(dot);

    assign div_trial = {div_rem, n_lo[Q_W-1]};
    assign div_ge    = (div_trial >= {1'b0, denom});

    isqrt_seq u_sqrt_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sq_go),
        .radicand (unsigned'(na2)),
        .root     (norm_a),
        .done     (sq_done_a)
    );

    isqrt_seq u_sqrt_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (sq_go),
        .radicand (unsigned'(nb2)),
        .root     (norm_b),
        .done     (sq_done_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sim     <= '0;
            valid   <= 1'b0;
            idx     <= '0;
            div_cnt <= '0;
            dot     <= '0;
            na2     <= '0;
            nb2     <= '0;
            sq_go   <= 1'b0;
            denom   <= '0;
            div_rem <= '0;
            n_lo    <= '0;
            quo     <= '0;
            ovf     <= 1'b0;
            neg     <= 1'b0;
            for (int i = 0; i < W; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            valid <= 1'b0;
            sq_go <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < W; i++) begin
                            a_q[i] <= signed'(vec_a[i]);
                            b_q[i] <= signed'(vec_b[i]);
                        end
                        idx   <= '0;
                        dot   <= '0;
                        na2   <= '0;
                        nb2   <= '0;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    dot <= dot + ACC_W'(p_ab);
                    na2 <= na2 + ACC_W'(p_aa);
                    nb2 <= nb2 + ACC_W'(p_bb);
                    if (idx == IDX_W'(W - 1)) begin
                        sq_go <= 1'b1;
                        state <= S_SQRT;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_SQRT: begin
                    if (sq_done_a && sq_done_b)
                        state <= S_MUL;
                end
                // Dividend is |dot|<<FRAC; only its top part seeds the
                // remainder, the low Q_W bits are shifted in one per cycle.
                // A seed >= denom means the quotient exceeds Q_W bits.
                S_MUL: begin
                    denom   <= prod;
                    div_rem <= abs_dot >> (Q_W - FRAC);
                    n_lo    <= {abs_dot[Q_W-FRAC-1:0], {FRAC{1'b0}}};
                    ovf     <= ((abs_dot >> (Q_W - FRAC)) >= prod);
                    neg     <= dot[ACC_W-1];
                    quo     <= '0;
                    div_cnt <= '0;
                    state   <= S_DIV;
                end
                S_DIV: begin
                    div_rem <= div_ge ? ACC_W'(div_trial - {1'b0, denom})
                                      : div_trial[ACC_W-1:0];
                    quo     <= {quo[Q_W-2:0], div_ge};
                    n_lo    <= n_lo << 1;
                    if (div_cnt == CNT_W'(DIV_CYC - 1))
                        state <= S_DONE;
                    else
                        div_cnt <= div_cnt + 1'b1;
                end
                S_DONE: begin
                    sim   <= shape_result(quo, ovf, neg, denom == '0);
                    valid <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cosine_sim.sv
// Scoreboard bench for cosine_sim: directed vectors queue their expected
// similarity and arrival cycle; a negedge monitor checks every valid pulse.
module tb_cosine_sim;

    localparam int W   = 5;
    localparam int LAT = W + 56;

    localparam logic [31:0] P1  = 32'h0000_8000;
    localparam logic [31:0] N1  = 32'hFFFF_8000;
    localparam logic [31:0] P2  = 32'h0001_0000;
    localparam logic [31:0] N3  = 32'hFFFE_8000;
    localparam logic [31:0] PH  = 32'h0000_4000;
    localparam logic [31:0] Z   = 32'h0000_0000;

    typedef logic [31:0] vec_t [W-1:0];

    typedef struct {
        logic signed [31:0] exp;
        int                 tol;
        int                 cyc;
        string              name;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [31:0]         vec_a [W-1:0];
    logic [31:0]         vec_b [W-1:0];
    logic signed [31:0]  sim;
    logic                valid;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_valid = 0;
    int   n_pushed = 0;
    int   cyc = 0;

    cosine_sim #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .vec_a (vec_a),
        .vec_b (vec_b),
        .sim   (sim),
        .valid (valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            n_valid++;
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid cycle=%0d sim=%0d", cyc, sim);
            end else begin
                e = sb.pop_front();
                n_chk++;
                if (sim < e.exp - e.tol || sim > e.exp + e.tol) begin
                    n_fail++;
                    $display("FAIL %s_value got=%0d want=%0d tol=%0d", e.name, sim, e.exp, e.tol);
                end
                n_chk++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s_latency got_cycle=%0d want_cycle=%0d", e.name, cyc, e.cyc);
                end
            end
        end
    end

    function automatic vec_t mk(input logic [31:0] e0, e1, e2, e3, e4);
        vec_t v;
        v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3; v[4] = e4;
        return v;
    endfunction

    task automatic scramble();
        for (int i = 0; i < W; i++) begin
            vec_a[i] = $urandom;
            vec_b[i] = $urandom;
        end
    endtask

    task automatic issue(input vec_t a, input vec_t b, input logic signed [31:0] exp,
                         input int tol, input string nm, input bit push);
        exp_t e;
        vec_a = a;
        vec_b = b;
        start = 1'b1;
        if (push) begin
            e.exp  = exp;
            e.tol  = tol;
            e.cyc  = cyc + 1 + LAT;
            e.name = nm;
            sb.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_empty(input string nm);
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout got_pending=%0d want_pending=0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scramble();
        idle(3);
        n_chk++;
        if (sim !== 32'sd0) begin
            n_fail++;
            $display("FAIL reset_sim got=%0d want=0", sim);
        end
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b want=0", valid);
        end
        rst_n = 1'b1;
        idle(2);

        issue(mk(P1, P1, P1, P1, P1), mk(P1, P1, P1, P1, P1), 32'sd32768, 0, "parallel", 1);
        wait_empty("parallel");
        issue(mk(P1, P1, P1, P1, P1), mk(N1, N1, N1, N1, N1), -32'sd32768, 0, "antiparallel", 1);
        wait_empty("antiparallel");
        issue(mk(P1, Z, Z, Z, Z), mk(Z, P1, Z, Z, Z), 32'sd0, 0, "orthogonal", 1);
        wait_empty("orthogonal");
        issue(mk(P1, P1, Z, Z, Z), mk(P1, Z, Z, Z, Z), 32'sd23170, 1, "diag45", 1);
        wait_empty("diag45");
        issue(mk(Z, Z, Z, Z, Z), mk(P1, P1, P1, P1, P1), 32'sd0, 0, "zero_a", 1);
        wait_empty("zero_a");
        idle(3);

        issue(mk(P1, Z, Z, Z, Z), mk(P1, P1, Z, Z, Z), 32'sd23170, 1, "busy_start", 1);
        idle(10);
        issue(mk(P1, P1, P1, P1, P1), mk(N1, N1, N1, N1, N1), 32'sd0, 0, "ignored", 0);
        wait_empty("busy_start");
        idle(80);

        issue(mk(P1, P1, P1, P1, P1), mk(P1, P1, P1, P1, P1), 32'sd0, 0, "aborted", 0);
        idle(W + 45);
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (sim !== 32'sd0) begin
            n_fail++;
            $display("FAIL abort_sim got=%0d want=0", sim);
        end
        n_chk++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_valid got=%b want=0", valid);
        end
        idle(2);
        rst_n = 1'b1;
        idle(2);
        issue(mk(P2, N3, PH, Z, P1), mk(P2, N3, PH, Z, P1), 32'sd32768, 0, "after_reset", 1);
        wait_empty("after_reset");
        idle(80);

        n_chk++;
        if (n_valid != n_pushed) begin
            n_fail++;
            $display("FAIL valid_count got=%0d want=%0d", n_valid, n_pushed);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
